// File: rtl/rng_share_arbiter.sv
// Shares one external LFSR among NUM_REQ lanes: warm-up after start, then one
// fresh word per cycle granted round-robin, advancing the LFSR once per grant.
module rng_share_arbiter #(
   parameter int unsigned NUM_REQ       = 4,
   parameter int unsigned WIDTH         = 8,
   parameter int unsigned WARMUP_CYCLES = 16,
   parameter int unsigned CNT_W         = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               halt,
   input  logic [WIDTH-1:0]   random_bits,
   output logic               lfsr_enable,
   input  logic [NUM_REQ-1:0] req,
   output logic [NUM_REQ-1:0] gnt,
   output logic [WIDTH-1:0]   rnd_data,
   output logic               rnd_valid,
   output logic               ready,
   output logic [CNT_W-1:0]   issued_cnt
);

   localparam int unsigned PTR_W  = $clog2(NUM_REQ);
   localparam int unsigned SUM_W  = PTR_W + 1;
   localparam int unsigned WCNT_W = 8;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WARMUP,
      ST_SERVE
   } state_e;

   state_e             state_q, state_d;
   logic [WCNT_W-1:0]  wcnt_q, wcnt_d;
   logic [PTR_W-1:0]   ptr_q, ptr_d;
   logic [NUM_REQ-1:0] gnt_q, gnt_d;
   logic [WIDTH-1:0]   rnd_data_q, rnd_data_d;
   logic               rnd_valid_q, rnd_valid_d;
   logic               ready_q, ready_d;
   logic [CNT_W-1:0]   issued_cnt_q, issued_cnt_d;
   logic               lfsr_en_c;

   logic [NUM_REQ-1:0] req_rot;
   logic [PTR_W-1:0]   win_off;
   logic [SUM_W-1:0]   win_sum;
   logic [PTR_W-1:0]   win_idx;
   logic [PTR_W-1:0]   win_next;

   // Rotate requests so the RR pointer lands on bit 0; lowest set bit wins.
   assign req_rot = NUM_REQ'({req, req} >> ptr_q);

   always_comb begin
      win_off = '0;
      for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
         if (req_rot[i]) win_off = PTR_W'(i);
      end
   end

   assign win_sum  = SUM_W'(ptr_q) + SUM_W'(win_off);
   assign win_idx  = (win_sum >= SUM_W'(NUM_REQ)) ? PTR_W'(win_sum - SUM_W'(NUM_REQ))
                                                  : PTR_W'(win_sum);
   assign win_next = (win_idx == PTR_W'(NUM_REQ - 1)) ? '0 : win_idx + PTR_W'(1);

   // Next-state and grant decision; halt overrides everything.
   always_comb begin
      state_d      = state_q;
      wcnt_d       = wcnt_q;
      ptr_d        = ptr_q;
      gnt_d        = '0;
      rnd_data_d   = rnd_data_q;
      rnd_valid_d  = 1'b0;
      issued_cnt_d = issued_cnt_q;
      lfsr_en_c    = 1'b0;
      if (halt) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  state_d = ST_WARMUP;
                  wcnt_d  = '0;
               end
            end
            ST_WARMUP: begin
               lfsr_en_c = 1'b1;
               wcnt_d    = wcnt_q + WCNT_W'(1);
               if (wcnt_q == WCNT_W'(WARMUP_CYCLES - 1)) state_d = ST_SERVE;
            end
            ST_SERVE: begin
               if (|req) begin
                  lfsr_en_c    = 1'b1;
                  gnt_d        = NUM_REQ'(1) << win_idx;
                  rnd_data_d   = random_bits;
                  rnd_valid_d  = 1'b1;
                  issued_cnt_d = issued_cnt_q + CNT_W'(1);
                  ptr_d        = win_next;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
      ready_d = (state_d == ST_SERVE);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         wcnt_q       <= '0;
         ptr_q        <= '0;
         gnt_q        <= '0;
         rnd_data_q   <= '0;
         rnd_valid_q  <= 1'b0;
         ready_q      <= 1'b0;
         issued_cnt_q <= '0;
      end else begin
         state_q      <= state_d;
         wcnt_q       <= wcnt_d;
         ptr_q        <= ptr_d;
         gnt_q        <= gnt_d;
         rnd_data_q   <= rnd_data_d;
         rnd_valid_q  <= rnd_valid_d;
         ready_q      <= ready_d;
         issued_cnt_q <= issued_cnt_d;
      end
   end

   // The LFSR must not advance while reset is being applied.
   assign lfsr_enable = lfsr_en_c & rst_n;
   assign gnt         = gnt_q;
   assign rnd_data    = rnd_data_q;
   assign rnd_valid   = rnd_valid_q;
   assign ready       = ready_q;
   assign issued_cnt  = issued_cnt_q;

endmodule

// File: doc/rng_share_arbiter.md
Name: rng_share_arbiter

Overview:
Shares the single 8-bit LFSR random source among NUM_REQ stochastic consumers (Bayesian sampling lanes). It sequences the LFSR through a warm-up phase after start, then grants one fresh random word per cycle to requesters in round-robin order. It drives the LFSR enable so that no two grants ever receive the same LFSR state.

Parameters:
NUM_REQ, 4, number of requesting lanes (2..16)
WIDTH, 8, random word width; matches LFSR output width
WARMUP_CYCLES, 16, LFSR advances performed before the first grant (1..255)
CNT_W, 16, width of the issued-word counter

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  synchronous active-low reset
start  in  1  pulse; leaves IDLE and begins warm-up
halt  in  1  level; returns to IDLE at the next edge, overriding all other inputs
random_bits  in  WIDTH  current LFSR state
lfsr_enable  out  1  advance LFSR this cycle (combinational from state/req)
req  in  NUM_REQ  per-lane request, level-sensitive
gnt  out  NUM_REQ  registered one-hot grant, one-cycle pulse per word
rnd_data  out  WIDTH  registered random word, valid with gnt
rnd_valid  out  1  registered, equals |gnt
ready  out  1  high while in SERVE
issued_cnt  out  CNT_W  words granted since reset, wraps to 0

Behaviour:
- Reset (rst_n=0 at an edge): state=IDLE, gnt=0, rnd_data=0, rnd_valid=0, issued_cnt=0, RR pointer=0, warm-up counter=0. Applies mid-operation; no partial grant survives.
- States: IDLE, WARMUP, SERVE.
- IDLE: lfsr_enable=0, ready=0. start=1 -> WARMUP, counter cleared.
- WARMUP: lfsr_enable=1 every cycle; counter increments; after exactly WARMUP_CYCLES WARMUP cycles -> SERVE. req ignored, gnt=0.
- SERVE: ready=1. lfsr_enable = |req (combinational). If any req: winner = first set bit searching upward from RR pointer, wrapping at NUM_REQ-1 to 0. Next edge: gnt<=onehot(winner), rnd_data<=random_bits (value sampled in the same cycle the LFSR is enabled), rnd_valid<=1, issued_cnt+=1, pointer<=winner+1 mod NUM_REQ. If no req: gnt<=0, rnd_valid<=0, rnd_data holds, LFSR holds.
- Latency: req seen in cycle t -> gnt/rnd_data in cycle t+1. A lane holding req high receives a grant at most every NUM_REQ cycles under full contention; with a single requester, a grant every cycle.
- Exactly one LFSR advance per grant in SERVE; consecutive grants carry consecutive LFSR states.
- halt=1: next state IDLE, gnt/rnd_valid<=0 at that edge, pointer and issued_cnt retained. halt has priority over start; start ignored outside IDLE.
- req bits dropping in the same cycle as a grant issued for them: grant still issued (decision used the previous cycle's req).
- issued_cnt wraps from 2^CNT_W-1 to 0 without stalling.

Test Plan:
- Reset then start with WARMUP_CYCLES=2, LFSR reset state 0xDA -> lfsr_enable high for exactly 2 cycles, LFSR reaches 0x6B, ready rises the following cycle, gnt stays 0.
- After that warm-up, req=0001 for 2 cycles -> gnt=0001 on two consecutive cycles with rnd_data 0x6B then 0xD6; issued_cnt=2.
- req=1111 held for 8 cycles from pointer 0 -> gnt sequence 0001,0010,0100,1000 repeated twice; all 8 rnd_data values are distinct consecutive LFSR states.
- req=0101 with pointer=1 -> grant order 0100, 0001, 0100; idle lanes 1 and 3 are never granted.
- halt asserted mid-SERVE with req=1111 -> gnt=0 and ready=0 from the next edge; lfsr_enable=0; a later start repeats the full warm-up.
- rst_n low for one edge during WARMUP and during SERVE -> all outputs zero and state IDLE at the next cycle; issued_cnt preset near 0xFFFF wraps to 0x0000 on the next grant.
